// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: owns the CPU memory bus and shares it between the 6502 core and the sprite (OAM) DMA engine.
// Latency: IDLE is a combinational pass-through. A transfer stalls the core for 513 ce-cycles, or 514 when an
//   ALIGN cycle is needed, counted from the cycle after the trigger write.
// Backpressure: the core is stalled by pulling cpu_ce low. All state advances only on ce=1, and the memory side
//   must qualify strobes with ce.
//
// Ports:
//   clk, reset            single clock; synchronous active-high reset
//   ce                    global clock enable
//   cpu_aout/dout/mr/mw   bus request from the CPU core
//   cpu_ce                clock enable back to the CPU core (low while DMA owns the bus)
//   mem_addr/dout/mr/mw   shared system bus; mem_din is same-cycle read data
//   dma_busy              high whenever the arbiter is not in IDLE
// Optional build macro DMC_DMA_EN adds the DMC sample-fetch steal: dmc_req, dmc_addr, dmc_ack, dmc_data.

module oam_dma_arbiter #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_PORT_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256      // byte index is 8 bits wide, so this must stay 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_aout,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mr,
    input  logic        cpu_mw,
    output logic        cpu_ce,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_mr,
    output logic        mem_mw,
    output logic        dma_busy
`ifdef DMC_DMA_EN
    ,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

`ifdef DMC_DMA_EN
    // DHALT/DREAD: steal started from IDLE. DSKIP: idle put cycle after a DMC read
    // that displaced an OAM read slot.
    typedef enum logic [2:0] {
        IDLE, HALT, ALIGN, READ, WRITE, DHALT, DREAD, DSKIP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, HALT, ALIGN, READ, WRITE
    } state_t;
`endif

    state_t     state;
    state_t     state_nxt;
    logic       parity;     // 0 = get cycle, 1 = put cycle
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data;

    logic       trig;       // trigger write seen in IDLE
    logic       data_ld;    // capture OAM read byte
    logic       idx_inc;    // OAM write completed
`ifdef DMC_DMA_EN
    logic       dmc_rd;     // DMC read on the bus this cycle
`endif

    // ------------------------------------------------------------------
    // Next state and bus decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cpu_ce    = 1'b0;
        dma_busy  = 1'b1;
        mem_addr  = cpu_aout;
        mem_dout  = cpu_dout;
        mem_mr    = 1'b0;
        mem_mw    = 1'b0;
        trig      = 1'b0;
        data_ld   = 1'b0;
        idx_inc   = 1'b0;
`ifdef DMC_DMA_EN
        dmc_rd    = 1'b0;
`endif

        case (state)
            IDLE: begin
                // Transparent: the trigger write itself also reaches memory.
                cpu_ce   = ce;
                dma_busy = 1'b0;
                mem_mr   = cpu_mr;
                mem_mw   = cpu_mw;
                if (cpu_mw && (cpu_aout == TRIGGER_ADDR)) begin
                    trig      = 1'b1;
                    state_nxt = HALT;
                end
`ifdef DMC_DMA_EN
                else if (dmc_req) begin
                    state_nxt = DHALT;
                end
`endif
            end

            // A halt on a put cycle leads straight into a get; otherwise one
            // extra ALIGN cycle pushes READ onto a get.
            HALT:  state_nxt = parity ? READ : ALIGN;

            ALIGN: state_nxt = READ;

            READ: begin
`ifdef DMC_DMA_EN
                if (dmc_req) begin
                    // DMC takes this get slot; the same idx is retried two cycles later.
                    mem_addr  = dmc_addr;
                    mem_mr    = 1'b1;
                    dmc_rd    = 1'b1;
                    state_nxt = DSKIP;
                end else
`endif
                begin
                    mem_addr  = {page, idx};
                    mem_mr    = 1'b1;
                    data_ld   = 1'b1;
                    state_nxt = WRITE;
                end
            end

            WRITE: begin
                mem_addr  = OAM_PORT_ADDR;
                mem_dout  = data;
                mem_mw    = 1'b1;
                idx_inc   = 1'b1;
                state_nxt = (idx == LAST_IDX) ? IDLE : READ;
            end

`ifdef DMC_DMA_EN
            DHALT: state_nxt = DREAD;

            DREAD: begin
                mem_addr  = dmc_addr;
                mem_mr    = 1'b1;
                dmc_rd    = 1'b1;
                state_nxt = IDLE;
            end

            DSKIP: state_nxt = READ;
`endif

            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers; everything holds while ce=0
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            idx    <= 8'h00;
            data   <= 8'h00;
        end else if (ce) begin
            state  <= state_nxt;
            parity <= ~parity;
            if (trig) begin
                page <= cpu_dout;
                idx  <= 8'h00;
            end
            if (data_ld) begin
                data <= mem_din;
            end
            if (idx_inc) begin
                idx <= idx + 8'h01;   // wraps to 0 after the last byte
            end
        end
    end

`ifdef DMC_DMA_EN
    // Acknowledge is a one-ce-cycle pulse following the DMC read.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmc_ack  <= 1'b0;
            dmc_data <= 8'h00;
        end else if (ce) begin
            dmc_ack <= dmc_rd;
            if (dmc_rd) begin
                dmc_data <= mem_din;
            end
        end
    end
`endif

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: directed stimulus with a scoreboard for bus writes, DMA reads and stall lengths.
// Latency: not applicable (bench).
// Backpressure: not applicable (bench).

module tb_oam_dma_arbiter;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] OAM  = 16'h2004;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [15:0] cpu_aout;
    logic [7:0]  cpu_dout;
    logic        cpu_mr;
    logic        cpu_mw;
    logic        cpu_ce;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_mr;
    logic        mem_mw;
    logic        dma_busy;
`ifdef DMC_DMA_EN
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic        dmc_ack;
    logic [7:0]  dmc_data;
`endif

    oam_dma_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .cpu_aout (cpu_aout),
        .cpu_dout (cpu_dout),
        .cpu_mr   (cpu_mr),
        .cpu_mw   (cpu_mw),
        .cpu_ce   (cpu_ce),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .mem_mr   (mem_mr),
        .mem_mw   (mem_mw),
        .dma_busy (dma_busy)
`ifdef DMC_DMA_EN
        ,
        .dmc_req  (dmc_req),
        .dmc_addr (dmc_addr),
        .dmc_ack  (dmc_ack),
        .dmc_data (dmc_data)
`endif
    );

    always #5 clk = ~clk;

    // Read-only memory model with same-cycle read data.
    logic [7:0] mem [0:65535];
    assign mem_din = mem[mem_addr];

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_wr[$];     // {addr, data} of every expected bus write
    logic [15:0] exp_rd[$];     // address of every expected read while busy
    int          exp_len[$];    // expected stall length (ce cycles with cpu_ce=0)
    int          exp_idle[$];   // expected strobe-free cycles within that stall

    logic tb_par;               // model of the get/put parity
    bit   chk_par = 1'b1;
    int   oam_wr_cnt = 0;
    int   ack_cnt = 0;
    int   run_len = 0;
    int   run_idle = 0;

    always @(posedge clk) begin
        if (reset)   tb_par <= 1'b0;
        else if (ce) tb_par <= ~tb_par;
    end

    // ------------------------------------------------------------------
    // Monitor: compares everything the DUT presents in ce cycles
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [23:0] ew;
        logic [15:0] er;
        int          el;
        int          ei;
        if (ce) begin
            if (mem_mw) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_dout);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({mem_addr, mem_dout} !== ew) begin
                        errors++;
                        $display("FAIL wr_data: got addr=%h data=%h, required addr=%h data=%h",
                                 mem_addr, mem_dout, ew[23:8], ew[7:0]);
                    end
                end
                if (dma_busy && mem_addr == OAM) oam_wr_cnt++;
            end
            if (mem_mr && dma_busy) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got addr=%h, required no read", mem_addr);
                end else begin
                    er = exp_rd.pop_front();
                    if (mem_addr !== er) begin
                        errors++;
                        $display("FAIL rd_addr: got %h required %h", mem_addr, er);
                    end
                end
                if (chk_par) begin
                    checks++;
                    if (tb_par !== 1'b0) begin
                        errors++;
                        $display("FAIL rd_parity: read at %h on parity %0d, required 0", mem_addr, tb_par);
                    end
                end
            end
            checks++;
            if (dma_busy !== !cpu_ce) begin
                errors++;
                $display("FAIL busy_vs_cpu_ce: dma_busy=%b cpu_ce=%b, required complementary", dma_busy, cpu_ce);
            end
            if (!cpu_ce) begin
                run_len++;
                if (!mem_mr && !mem_mw) run_idle++;
            end else if (run_len != 0) begin
                checks++;
                if (exp_len.size() == 0) begin
                    errors++;
                    $display("FAIL stall_unexpected: got %0d cycles, required none", run_len);
                end else begin
                    el = exp_len.pop_front();
                    ei = exp_idle.pop_front();
                    if (run_len != el || run_idle != ei) begin
                        errors++;
                        $display("FAIL stall_len: got %0d cycles (%0d idle), required %0d (%0d idle)",
                                 run_len, run_idle, el, ei);
                    end
                end
                run_len  = 0;
                run_idle = 0;
            end
`ifdef DMC_DMA_EN
            if (dmc_ack) ack_cnt++;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic wait_wr(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk); #1;
            if (oam_wr_cnt >= n) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_wr_timeout: got %0d OAM writes, required %0d", oam_wr_cnt, n);
        end
    endtask

`ifdef DMC_DMA_EN
    task automatic wait_ack();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); #1;
            if (dmc_ack) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dmc_ack_timeout: got no ack, required one within 50 cycles");
        end
    endtask
`endif

    // One OAM transfer. halt_par selects the parity HALT lands on; stop < 256
    // asserts reset after that many bytes; ce_gap >= 0 freezes ce after that
    // many bytes; dmc_at >= 0 raises dmc_req for the READ slot of that byte.
    task automatic run_oam(input logic [7:0] pg, input logic halt_par, input int stop,
                           input int ce_gap, input int dmc_at);
        int  base;
        int  a0;
        bit  done;
        logic [15:0] a;
        // Trigger cycle parity is the opposite of the HALT cycle parity.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (tb_par == !halt_par) break;
        end
        exp_wr.push_back({TRIG, pg});
        for (int i = 0; i < stop; i++) begin
            a = {pg, 8'(i)};
`ifdef DMC_DMA_EN
            if (i == dmc_at) exp_rd.push_back(dmc_addr);
`endif
            exp_rd.push_back(a);
            exp_wr.push_back({OAM, mem[a]});
        end
        exp_len.push_back(1 + (halt_par ? 0 : 1) + 2 * stop + (dmc_at >= 0 ? 2 : 0));
        exp_idle.push_back(1 + (halt_par ? 0 : 1) + (dmc_at >= 0 ? 1 : 0));
        base = oam_wr_cnt;
        a0   = ack_cnt;
        cpu_aout = TRIG; cpu_dout = pg; cpu_mw = 1'b1; cpu_mr = 1'b0;
        @(posedge clk); #1;
        // A stalled core keeps driving a read that must not leak onto the bus.
        cpu_mw = 1'b0; cpu_aout = 16'h5555; cpu_mr = 1'b1;
        if (ce_gap >= 0) begin
            wait_wr(base + ce_gap);
            @(posedge clk); #1;
            ce = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); #1;
                chk("ce0_cpu_ce", cpu_ce, 0);
                chk("ce0_busy", dma_busy, 1);
            end
            @(posedge clk); #1;
            ce = 1'b1;
        end
`ifdef DMC_DMA_EN
        if (dmc_at >= 0) begin
            wait_wr(base + dmc_at);
            dmc_req = 1'b1;
            wait_ack();
            dmc_req = 1'b0;
            chk("dmc_data_oam", dmc_data, mem[dmc_addr]);
        end
`endif
        if (stop < 256) begin
            wait_wr(base + stop);
            reset = 1'b1;
            @(posedge clk); #1;
            chk("rst_busy", dma_busy, 0);
            chk("rst_cpu_ce", cpu_ce, 1);
            reset = 1'b0;
        end else begin
            done = 1'b0;
            for (int i = 0; i < 1200 && !done; i++) begin
                @(posedge clk); #1;
                if (!dma_busy) done = 1'b1;
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL dma_timeout: dma_busy still high after 1200 cycles, required low");
            end
        end
        cpu_mr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (dmc_at >= 0) chk("dmc_ack_once", 32'(ack_cnt - a0), 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
        end
        for (int i = 0; i < 256; i++) begin
            mem[16'hFF00 + i] = ~8'(i);
        end
        reset = 1'b1; ce = 1'b1;
        cpu_aout = 16'h0000; cpu_dout = 8'h00; cpu_mr = 1'b0; cpu_mw = 1'b0;
`ifdef DMC_DMA_EN
        dmc_req = 1'b0; dmc_addr = 16'hC0DE;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state_busy", dma_busy, 0);
        chk("rst_state_cpu_ce", cpu_ce, 1);
        reset = 1'b0;

        // Idle pass-through.
        cpu_aout = 16'h1234; cpu_mr = 1'b1; cpu_dout = 8'hA5;
        @(posedge clk); #1;
        chk("idle_addr", mem_addr, 16'h1234);
        chk("idle_mr", mem_mr, 1);
        chk("idle_mw", mem_mw, 0);
        chk("idle_dout", mem_dout, 8'hA5);
        chk("idle_cpu_ce", cpu_ce, 1);
        chk("idle_busy", dma_busy, 0);
        ce = 1'b0; #1;
        chk("idle_ce0_cpu_ce", cpu_ce, 0);
        @(posedge clk); #1;
        ce = 1'b1;
        // Ordinary CPU write that is not the trigger.
        cpu_mr = 1'b0; cpu_aout = 16'h0300; cpu_dout = 8'h77; cpu_mw = 1'b1;
        exp_wr.push_back({16'h0300, 8'h77});
        @(posedge clk); #1;
        cpu_mw = 1'b0;
        chk("nontrig_busy", dma_busy, 0);

        run_oam(8'h02, 1'b1, 256, 50, -1);   // HALT on put: 513 cycles, with a ce=0 gap
        run_oam(8'h02, 1'b0, 256, -1, -1);   // HALT on get: ALIGN, 514 cycles
        run_oam(8'hFF, 1'b1, 256, -1, -1);   // last page, data FF..00
        run_oam(8'h03, 1'b1, 100, -1, -1);   // reset after byte 99
`ifdef DMC_DMA_EN
        run_oam(8'h04, 1'b1, 256, -1, 10);   // DMC steal at byte 10: 515 cycles
        begin
            int a0;
            a0 = ack_cnt;
            chk_par = 1'b0;
            exp_rd.push_back(dmc_addr);
            exp_len.push_back(2);
            exp_idle.push_back(1);
            @(posedge clk); #1;
            dmc_req = 1'b1;
            wait_ack();
            dmc_req = 1'b0;
            chk("dmc_data_idle", dmc_data, mem[dmc_addr]);
            repeat (3) @(posedge clk);
            #1;
            chk("dmc_ack_idle_once", 32'(ack_cnt - a0), 1);
            chk_par = 1'b1;
        end
`endif

        repeat (10) @(posedge clk);
        #1;
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_rd_drained", exp_rd.size(), 0);
        chk("exp_len_drained", exp_len.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
